// File: rtl/display_pkg.sv
// Shared constants for the 7-segment LED scanner: blank levels and hex segment table.
package display_pkg;

    // Active-low idle levels for a dark digit slot.
    localparam logic [7:0] AN_BLANK  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_BLANK  = 1'b1;

    // Active-low segment codes {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    // Leftmost element lands in index 15.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment decode.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Straight table lookup.
    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/led_display_scan.sv
// Multiplexed 8-digit hex LED scanner with frame-synchronous shadow capture.
module led_display_scan
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        en,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CntW    = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] DivLast = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic            frame_done_d;
    logic            tick;
    logic [7:0]      an_d;
    logic [6:0]      seg_d;
    logic            dp_d;
    logic [3:0]      nibble;
    logic [31:0]     upper;
    logic            digit_blank;
    logic [6:0]      seg_hex;

    // Divider, digit index and shadow capture; shadow only moves at the end of slot 7.
    always_comb begin
        tick         = (div_cnt_q == DivLast);
        div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        frame_done_d = tick && (idx_q == 3'd7);
        shadow_d     = frame_done_d ? data : shadow_q;
    end

    // Per-slot digit selection and blanking; upper holds this digit and everything above it.
    always_comb begin
        nibble      = shadow_q[{idx_q, 2'b00} +: 4];
        upper       = shadow_q >> {idx_q, 2'b00};
        digit_blank = !en || (blank_lz && (idx_q != 3'd0) && (upper == 32'd0));
        an_d        = digit_blank ? AN_BLANK  : ~(8'd1 << idx_q);
        seg_d       = digit_blank ? SEG_BLANK : seg_hex;
        dp_d        = digit_blank ? DP_BLANK  : ~dp_mask[idx_q];
    end

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_o    (seg_hex)
    );

    // All state, including the registered display outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            idx_q      <= 3'd0;
            shadow_q   <= 32'd0;
            frame_done <= 1'b0;
            an         <= AN_BLANK;
            seg        <= SEG_BLANK;
            dp         <= DP_BLANK;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            frame_done <= frame_done_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
        end
    end

endmodule
